// File: rtl/csr_file_if.sv
// CSR access bus between the pipeline control block (master) and the
// machine-mode CSR file (slave).
interface csr_file_if;
  logic        csr_r_en_i;
  logic [12:0] csr_addr_i;
  logic [1:0]  csr_op_mode_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_exception_o;

  modport master (
    output csr_r_en_i,
    output csr_addr_i,
    output csr_op_mode_i,
    output csr_wdata_i,
    input  csr_rdata_o,
    input  csr_exception_o
  );

  modport slave (
    input  csr_r_en_i,
    input  csr_addr_i,
    input  csr_op_mode_i,
    input  csr_wdata_i,
    output csr_rdata_o,
    output csr_exception_o
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR register file and trap unit (RV32I, single hart).
// Serves atomic read/modify/write CSR accesses, flags illegal accesses,
// records trap state and supplies the trap/return redirect PC.
module csr_file #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h40000100,
  parameter logic [31:0] MTVEC_RST = 32'h00000004
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  csr_file_if.slave         bus,
  input  logic              exception_i,
  input  logic [31:0]       excep_code_i,
  input  logic              load_mcause_i,
  input  logic [31:0]       excep_pc_i,
  input  logic              ret_i,
  output logic [31:0]       trap_pc_o,
  output logic              pc_load_trap_o
);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RW   = 2'd1,
    OP_SET  = 2'd2,
    OP_CLR  = 2'd3
  } csr_op_e;

  // Architectural state
  logic        mie_q;
  logic        mpie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle_q;

  // Access decode
  logic [31:0] mstatus_rd;
  logic [31:0] rd_val;
  logic [31:0] wr_val;
  logic        impl;
  logic        read_only;
  logic        wr_req;
  logic        illegal;
  logic        wr_en;
  logic        trap_evt;
  logic        ret_evt;
  logic        evt;
  csr_op_e     op;

  function automatic logic [31:0] csr_modify(input csr_op_e mode,
                                             input logic [31:0] old_v,
                                             input logic [31:0] wd);
    case (mode)
      OP_RW:   csr_modify = wd;
      OP_SET:  csr_modify = old_v | wd;
      OP_CLR:  csr_modify = old_v & ~wd;
      default: csr_modify = old_v;
    endcase
  endfunction

  assign op         = csr_op_e'(bus.csr_op_mode_i);
  // MPP is hardwired to machine mode
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  // A trap wins over a simultaneous return
  assign trap_evt   = exception_i;
  assign ret_evt    = ret_i & ~exception_i;
  assign evt        = trap_evt | ret_evt;

  // Address decode, legality check and modify value
  always_comb begin
    rd_val    = 32'b0;
    impl      = 1'b1;
    read_only = 1'b0;
    case (bus.csr_addr_i[11:0])
      12'h300: rd_val = mstatus_rd;
      12'h301: begin rd_val = MISA_VAL; read_only = 1'b1; end
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h343: rd_val = mtval_q;
      12'hB00: rd_val = mcycle_q[31:0];
      12'hB80: rd_val = mcycle_q[63:32];
      12'hF14: begin rd_val = HART_ID; read_only = 1'b1; end
      default: impl = 1'b0;
    endcase
    wr_req  = (op != OP_NONE);
    illegal = bus.csr_addr_i[12] | ~impl |
              (wr_req & (read_only | (bus.csr_addr_i[11:10] == 2'b11)));
    wr_en   = bus.csr_r_en_i & ~illegal & wr_req;
    wr_val  = csr_modify(op, rd_val, bus.csr_wdata_i);
  end

  // CSR state update: trap/return take priority over writes to trap CSRs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'b0;
      mepc_q     <= 32'b0;
      mcause_q   <= 32'b0;
      mtval_q    <= 32'b0;
      mcycle_q   <= 64'b0;
    end else begin
      if (trap_evt) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (ret_evt) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr_en && bus.csr_addr_i[11:0] == 12'h300) begin
        mie_q  <= wr_val[3];
        mpie_q <= wr_val[7];
      end

      if (trap_evt) begin
        mepc_q <= excep_pc_i & ~32'h3;
      end else if (!evt && wr_en && bus.csr_addr_i[11:0] == 12'h341) begin
        mepc_q <= wr_val & ~32'h3;
      end

      if (trap_evt) begin
        if (load_mcause_i) mcause_q <= excep_code_i;
      end else if (!evt && wr_en && bus.csr_addr_i[11:0] == 12'h342) begin
        mcause_q <= wr_val;
      end

      if (trap_evt) begin
        mtval_q <= 32'b0;
      end else if (!evt && wr_en && bus.csr_addr_i[11:0] == 12'h343) begin
        mtval_q <= wr_val;
      end

      if (wr_en && bus.csr_addr_i[11:0] == 12'h305) mtvec_q    <= wr_val & ~32'h3;
      if (wr_en && bus.csr_addr_i[11:0] == 12'h340) mscratch_q <= wr_val;

      // A write to either half replaces it and holds the counter that cycle
      if (wr_en && bus.csr_addr_i[11:0] == 12'hB00) begin
        mcycle_q[31:0] <= wr_val;
      end else if (wr_en && bus.csr_addr_i[11:0] == 12'hB80) begin
        mcycle_q[63:32] <= wr_val;
      end else begin
        mcycle_q <= mcycle_q + 64'd1;
      end
    end
  end

  // Registered read data, illegal-access pulse and PC redirect pulse
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.csr_rdata_o     <= 32'b0;
      bus.csr_exception_o <= 1'b0;
      trap_pc_o           <= 32'b0;
      pc_load_trap_o      <= 1'b0;
    end else begin
      bus.csr_exception_o <= bus.csr_r_en_i & illegal;
      if (bus.csr_r_en_i) bus.csr_rdata_o <= illegal ? 32'b0 : rd_val;
      pc_load_trap_o <= evt;
      if (trap_evt)     trap_pc_o <= mtvec_q;
      else if (ret_evt) trap_pc_o <= mepc_q;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: table-driven CSR accesses checked through a
// scoreboard queue, plus hand-written trap, return, counter and reset
// sequences.
module tb_csr_file;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        exception_i;
  logic [31:0] excep_code_i;
  logic        load_mcause_i;
  logic [31:0] excep_pc_i;
  logic        ret_i;
  logic [31:0] trap_pc_o;
  logic        pc_load_trap_o;

  csr_file_if bus();

  csr_file #(
    .HART_ID  (32'd0),
    .MISA_VAL (32'h40000100),
    .MTVEC_RST(32'h00000004)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .bus           (bus),
    .exception_i   (exception_i),
    .excep_code_i  (excep_code_i),
    .load_mcause_i (load_mcause_i),
    .excep_pc_i    (excep_pc_i),
    .ret_i         (ret_i),
    .trap_pc_o     (trap_pc_o),
    .pc_load_trap_o(pc_load_trap_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [1:0] NONE = 2'd0, RW = 2'd1, SET = 2'd2, CLR = 2'd3;

  typedef struct {
    logic [31:0] rd;
    logic        exc;
    logic        rd_chk;
    int          tag;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [12:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        exc;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[20];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Queue the expected response and present the access for the next edge
  task automatic drive_acc(input logic [1:0] op, input logic [12:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input logic exc, input logic rdc);
    exp_t e;
    e.rd = rd; e.exc = exc; e.rd_chk = rdc; e.tag = tag_cnt;
    tag_cnt++;
    sb.push_back(e);
    bus.csr_r_en_i    = 1'b1;
    bus.csr_op_mode_i = op;
    bus.csr_addr_i    = addr;
    bus.csr_wdata_i   = wd;
  endtask

  task automatic clr_acc();
    bus.csr_r_en_i    = 1'b0;
    bus.csr_op_mode_i = NONE;
    bus.csr_addr_i    = 13'h0;
    bus.csr_wdata_i   = 32'h0;
  endtask

  task automatic acc(input logic [1:0] op, input logic [12:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input logic exc);
    drive_acc(op, addr, wd, rd, exc, 1'b1);
    @(negedge clk_i);
    clr_acc();
  endtask

  // Scoreboard: each accepted access is compared one step after its edge
  always @(posedge clk_i) begin
    if (rst_n_i && bus.csr_r_en_i) begin
      #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got rdata=%h exc=%b, expected no response",
                 bus.csr_rdata_o, bus.csr_exception_o);
      end else begin
        mon_e = sb.pop_front();
        if ((mon_e.rd_chk && bus.csr_rdata_o !== mon_e.rd) ||
            bus.csr_exception_o !== mon_e.exc) begin
          n_bad++;
          $display("FAIL rd#%0d: got rdata=%h exc=%b, expected rdata=%h exc=%b",
                   mon_e.tag, bus.csr_rdata_o, bus.csr_exception_o, mon_e.rd, mon_e.exc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{NONE, 13'h0300, 32'h0,        32'h00001800, 1'b0};
    tbl[1]  = '{NONE, 13'h0301, 32'h0,        32'h40000100, 1'b0};
    tbl[2]  = '{NONE, 13'h0F14, 32'h0,        32'h00000000, 1'b0};
    tbl[3]  = '{NONE, 13'h0305, 32'h0,        32'h00000004, 1'b0};
    tbl[4]  = '{RW,   13'h0340, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[5]  = '{SET,  13'h0340, 32'h0000000F, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{CLR,  13'h0340, 32'hF0000000, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{NONE, 13'h0340, 32'h0,        32'h0EADBEEF, 1'b0};
    tbl[8]  = '{RW,   13'h0301, 32'h12345678, 32'h00000000, 1'b1};
    tbl[9]  = '{NONE, 13'h0301, 32'h0,        32'h40000100, 1'b0};
    tbl[10] = '{RW,   13'h07C0, 32'h00000001, 32'h00000000, 1'b1};
    tbl[11] = '{RW,   13'h1340, 32'h00000000, 32'h00000000, 1'b1};
    tbl[12] = '{SET,  13'h0F14, 32'h00000005, 32'h00000000, 1'b1};
    tbl[13] = '{NONE, 13'h0340, 32'h0,        32'h0EADBEEF, 1'b0};
    tbl[14] = '{RW,   13'h0305, 32'h00000107, 32'h00000004, 1'b0};
    tbl[15] = '{RW,   13'h0305, 32'h00000004, 32'h00000104, 1'b0};
    tbl[16] = '{RW,   13'h0343, 32'h00000ABC, 32'h00000000, 1'b0};
    tbl[17] = '{NONE, 13'h0343, 32'h0,        32'h00000ABC, 1'b0};
    tbl[18] = '{NONE, 13'h0F14, 32'h0,        32'h00000000, 1'b0};
    tbl[19] = '{NONE, 13'h1300, 32'h0,        32'h00000000, 1'b1};

    rst_n_i       = 1'b0;
    exception_i   = 1'b0;
    excep_code_i  = 32'h0;
    load_mcause_i = 1'b0;
    excep_pc_i    = 32'h0;
    ret_i         = 1'b0;
    clr_acc();

    #12;
    chk("rst_rdata", bus.csr_rdata_o, 32'h0);
    chk("rst_exc", {31'b0, bus.csr_exception_o}, 32'h0);
    chk("rst_pc_load", {31'b0, pc_load_trap_o}, 32'h0);
    chk("rst_trap_pc", trap_pc_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 20; i++)
      acc(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].exc);

    // Trap then return
    acc(RW, 13'h300, 32'h8, 32'h1800, 1'b0);
    acc(NONE, 13'h300, 32'h0, 32'h1808, 1'b0);
    exception_i = 1'b1; excep_pc_i = 32'h107; excep_code_i = 32'd11; load_mcause_i = 1'b1;
    @(negedge clk_i);
    chk("trap_pulse", {31'b0, pc_load_trap_o}, 32'h1);
    chk("trap_pc", trap_pc_o, 32'h4);
    exception_i = 1'b0; load_mcause_i = 1'b0;
    @(negedge clk_i);
    chk("trap_pulse_end", {31'b0, pc_load_trap_o}, 32'h0);
    acc(NONE, 13'h341, 32'h0, 32'h104, 1'b0);
    acc(NONE, 13'h342, 32'h0, 32'd11, 1'b0);
    acc(NONE, 13'h300, 32'h0, 32'h1880, 1'b0);
    acc(NONE, 13'h343, 32'h0, 32'h0, 1'b0);
    ret_i = 1'b1;
    @(negedge clk_i);
    chk("ret_pulse", {31'b0, pc_load_trap_o}, 32'h1);
    chk("ret_pc", trap_pc_o, 32'h104);
    ret_i = 1'b0;
    @(negedge clk_i);
    chk("ret_pulse_end", {31'b0, pc_load_trap_o}, 32'h0);
    acc(NONE, 13'h300, 32'h0, 32'h1888, 1'b0);

    // Exception, return and mepc write all in one cycle
    drive_acc(RW, 13'h341, 32'h200, 32'h104, 1'b0, 1'b1);
    exception_i = 1'b1; ret_i = 1'b1; excep_pc_i = 32'h300;
    excep_code_i = 32'd2; load_mcause_i = 1'b0;
    @(negedge clk_i);
    chk("coll_pulse", {31'b0, pc_load_trap_o}, 32'h1);
    chk("coll_pc", trap_pc_o, 32'h4);
    clr_acc(); exception_i = 1'b0; ret_i = 1'b0;
    @(negedge clk_i);
    chk("coll_pulse_end", {31'b0, pc_load_trap_o}, 32'h0);
    acc(NONE, 13'h341, 32'h0, 32'h300, 1'b0);
    acc(NONE, 13'h342, 32'h0, 32'd11, 1'b0);
    acc(NONE, 13'h300, 32'h0, 32'h1880, 1'b0);

    // mtvec write alongside a trap: redirect uses the old mtvec
    drive_acc(RW, 13'h305, 32'h40, 32'h4, 1'b0, 1'b1);
    exception_i = 1'b1; excep_pc_i = 32'h208; excep_code_i = 32'd7; load_mcause_i = 1'b1;
    @(negedge clk_i);
    chk("mtvec_coll_pc", trap_pc_o, 32'h4);
    clr_acc(); exception_i = 1'b0; load_mcause_i = 1'b0;
    acc(NONE, 13'h305, 32'h0, 32'h40, 1'b0);
    acc(NONE, 13'h342, 32'h0, 32'd7, 1'b0);
    acc(NONE, 13'h341, 32'h0, 32'h208, 1'b0);
    acc(NONE, 13'h300, 32'h0, 32'h1800, 1'b0);

    // Cycle counter wrap and write suppression
    drive_acc(RW, 13'hB00, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    clr_acc();
    repeat (3) @(negedge clk_i);
    acc(NONE, 13'hB00, 32'h0, 32'h1, 1'b0);
    acc(NONE, 13'hB80, 32'h0, 32'h1, 1'b0);
    drive_acc(RW, 13'hB00, 32'h10, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    clr_acc();
    acc(RW, 13'hB80, 32'h5, 32'h1, 1'b0);
    acc(NONE, 13'hB00, 32'h0, 32'h10, 1'b0);
    acc(NONE, 13'hB80, 32'h0, 32'h5, 1'b0);

    // Reset in the middle of a redirect pulse
    acc(RW, 13'h340, 32'h55, 32'h0EADBEEF, 1'b0);
    exception_i = 1'b1; excep_pc_i = 32'h400; load_mcause_i = 1'b1;
    @(posedge clk_i);
    #2;
    chk("pre_rst_pulse", {31'b0, pc_load_trap_o}, 32'h1);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_pulse", {31'b0, pc_load_trap_o}, 32'h0);
    chk("mid_rst_trap_pc", trap_pc_o, 32'h0);
    chk("mid_rst_rdata", bus.csr_rdata_o, 32'h0);
    exception_i = 1'b0; load_mcause_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    acc(NONE, 13'h340, 32'h0, 32'h0, 1'b0);
    acc(NONE, 13'h300, 32'h0, 32'h1800, 1'b0);
    acc(NONE, 13'h305, 32'h0, 32'h4, 1'b0);
    acc(NONE, 13'h341, 32'h0, 32'h0, 1'b0);

    repeat (2) @(negedge clk_i);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
